// File: rtl/serial_tx_if.sv
// serial_tx_if: word handshake between a requester and serial_tx.
//
// Handshake: a word moves across the link on any rising clk edge where
// tx_valid and tx_ready are both high. The requester holds tx_data stable
// while tx_valid is high and it is waiting for tx_ready. tx_ready never
// depends combinationally on tx_valid.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: serialises a DATA_W word onto a single idle-high line.
// The frame is a start bit (0), then the data bits LSB first, then an
// optional even parity bit, then a stop bit (1). Each bit is held for
// CLKS_PER_BIT cycles. All outputs are registered.
// Build option: define SERIAL_TX_PARITY_EN to insert the even parity bit.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus,
  output logic        tx_out,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic              ready_q;
  logic              cyc_last;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_bit;
`endif

  // The next data bit to present is the LSB of the shifted register.
  assign sh_next  = shreg >> 1;
  assign cyc_last = (cyc_cnt == CYC_LAST);
  assign bus.tx_ready = ready_q;

  // Frame sequencer: state, counters, shift register and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      tx_out     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          // ready_q is high in IDLE, so tx_valid alone completes the handshake.
          if (bus.tx_valid && ready_q) begin
            shreg      <= bus.tx_data;
            state      <= START;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            tx_out     <= 1'b0;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= ^bus.tx_data;
`endif
          end
        end

        START: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= DATA;
            tx_out  <= shreg[0];
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            shreg   <= sh_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state   <= PARITY;
              tx_out  <= parity_bit;
`else
              state   <= STOP;
              tx_out  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= sh_next[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= STOP;
            tx_out  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cyc_last) begin
            cyc_cnt <= '0;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            tx_out  <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          ready_q <= 1'b1;
          busy    <= 1'b0;
          tx_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx. Instance a runs at
// CLKS_PER_BIT=4, instance b at CLKS_PER_BIT=1. Expected per-cycle
// {tx_ready, busy, tx_out} triples are queued when a word is sent and
// popped one per cycle while the frame is on the line.
module tb_serial_tx;

  localparam int W = 3;

  logic clk;
  logic rst;
  logic out_a, busy_a;
  logic out_b, busy_b;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  serial_tx_if #(.DATA_W(8)) if_a ();
  serial_tx_if #(.DATA_W(8)) if_b ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_a (
    .clk    (clk),
    .rst    (rst),
    .bus    (if_a),
    .tx_out (out_a),
    .busy   (busy_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
    .clk    (clk),
    .rst    (rst),
    .bus    (if_b),
    .tx_out (out_b),
    .busy   (busy_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Idle: ready=1 busy=0 out=1.
  localparam logic [W-1:0] IDLE_V = 3'b101;

  // Compare the observed {ready, busy, out} of one instance with exp.
  task automatic check_cycle(input bit sel, input logic [W-1:0] exp, input string tag);
    logic [W-1:0] obs;
    obs = sel ? {if_b.tx_ready, busy_b, out_b} : {if_a.tx_ready, busy_a, out_a};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Queue the expected line for a whole frame of word d.
  task automatic push_frame(input int cpb, input logic [7:0] d);
    for (int c = 0; c < cpb; c++) exp_q.push_back(3'b010);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < cpb; c++) exp_q.push_back({2'b01, d[i]});
`ifdef SERIAL_TX_PARITY_EN
    for (int c = 0; c < cpb; c++) exp_q.push_back({2'b01, ^d});
`endif
    for (int c = 0; c < cpb; c++) exp_q.push_back(3'b011);
  endtask

  // Pop and check one entry per cycle until the queue is empty.
  task automatic drain(input bit sel, input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_cycle(sel, e, tag);
      @(negedge clk);
    end
  endtask

  // Called at a negedge while the instance is idle: present one word for
  // one edge, then return in the first cycle of the frame.
  task automatic send(input bit sel, input logic [7:0] d, input string tag);
    check_cycle(sel, IDLE_V, {tag, "_ready"});
    if (sel) begin
      if_b.tx_data = d; if_b.tx_valid = 1'b1;
    end else begin
      if_a.tx_data = d; if_a.tx_valid = 1'b1;
    end
    @(negedge clk);
    if (sel) if_b.tx_valid = 1'b0;
    else     if_a.tx_valid = 1'b0;
    push_frame(sel ? 1 : 4, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'h5A;
    if_b.tx_valid = 1'b0;
    if_b.tx_data  = 8'h00;

    // Reset held two cycles with tx_valid high: nothing starts.
    @(negedge clk);
    check_cycle(0, IDLE_V, "reset_c1");
    check_cycle(1, IDLE_V, "reset_b");
    @(negedge clk);
    check_cycle(0, IDLE_V, "reset_c2");
    rst = 1'b0;
    // First accept at the edge right after release.
    @(negedge clk);
    if_a.tx_valid = 1'b0;
    push_frame(4, 8'h5A);
    drain(0, "post_reset_5a");
    check_cycle(0, IDLE_V, "post_reset_idle");

    // tx_valid low: stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cycle(0, IDLE_V, "idle_hold");
    end

    // Single frame 0xA5 (parity bit 0 when enabled).
    @(negedge clk);
    send(0, 8'hA5, "a5");
    drain(0, "frame_a5");
    check_cycle(0, IDLE_V, "a5_done");

    // 0x07 (parity bit 1 when enabled).
    @(negedge clk);
    send(0, 8'h07, "07");
    drain(0, "frame_07");
    check_cycle(0, IDLE_V, "07_done");

    // Back-to-back at CLKS_PER_BIT=1 with tx_valid held high.
    @(negedge clk);
    check_cycle(1, IDLE_V, "b2b_ready");
    if_b.tx_data  = 8'h00;
    if_b.tx_valid = 1'b1;
    @(negedge clk);
    if_b.tx_data = 8'hFF;  // changed mid-frame; must not disturb frame 1
    push_frame(1, 8'h00);
    drain(1, "b2b_frame0");
    check_cycle(1, IDLE_V, "b2b_gap");
    @(negedge clk);
    if_b.tx_valid = 1'b0;
    push_frame(1, 8'hFF);
    drain(1, "b2b_frame1");
    check_cycle(1, IDLE_V, "b2b_done");

    // Reset during data bit 3 of 0x3C (frame cycles 13..16).
    @(negedge clk);
    send(0, 8'h3C, "3c");
    for (int i = 0; i < 14; i++) begin
      check_cycle(0, exp_q.pop_front(), "frame_3c_head");
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_cycle(0, IDLE_V, "midframe_reset");
    @(negedge clk);
    check_cycle(0, IDLE_V, "midframe_reset_hold");

    // Fresh word after the abandoned frame.
    send(0, 8'h81, "81");
    drain(0, "frame_81");
    check_cycle(0, IDLE_V, "81_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Single-channel serial transmitter that serializes a parallel word onto one line, framed as start bit, data bits LSB first, optional parity bit, and stop bit. It is the sending end of the team's serial bit link, and its output line feeds the latch-based receiver path. Words enter through a valid/ready handshake from the local stimulus/control logic. The line idles high.

## Interface
- `DATA_W`, default 8: data word width, ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles each bit is held on the line, ≥1.

- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous reset, active-high, sampled on `clk` rising edge.
- `tx_data`  input  DATA_W  word to send; sampled only at handshake.
- `tx_valid`  input  1  requester has a word on `tx_data`.
- `tx_ready`  output  1  block can accept a word this cycle.
- `tx_out`  output  1  serial line; idle/stop = 1, start = 0.
- `busy`  output  1  frame in progress (any state other than IDLE).

One clock; reset is synchronous and active-high. All outputs are registered.

## Operation
- States:
  - IDLE: `tx_out`=1, `tx_ready`=1, `busy`=0.
  - START: `tx_out`=0.
  - DATA: `tx_out`=current data bit.
  - PARITY: present only with the macro.
  - STOP: `tx_out`=1.
- Transitions:
  - IDLE→START on `tx_valid && tx_ready`.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→DATA for each of the DATA_W bits, CLKS_PER_BIT cycles per bit.
  - After the last data bit: DATA→PARITY with the macro, otherwise DATA→STOP.
  - PARITY→STOP after CLKS_PER_BIT cycles.
  - STOP→IDLE after CLKS_PER_BIT cycles.
- Handshake: the word is copied into an internal shift register on the accepting edge. Later changes on `tx_data` and `tx_valid` have no effect until the block returns to IDLE.
- Bit order: LSB first. The shift register shifts right once per bit period.
- Counters:
  - Cycle counter width $clog2(CLKS_PER_BIT), minimum 1 bit. It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index counter width $clog2(DATA_W+1). It wraps to 0 on leaving DATA.
- CLKS_PER_BIT=1: every state lasts exactly one cycle. No stall or skipped bit is allowed.
- `tx_valid` low in IDLE: the block stays in IDLE and `tx_out` stays 1.
- Reset values: state=IDLE, `tx_out`=1, `tx_ready`=1, `busy`=0, counters=0, shift register=0. While `rst`=1, no handshake is accepted, even if `tx_valid`=1.
- Reset mid-frame: on the next edge the block returns to IDLE with `tx_out`=1. The frame is abandoned with no completion, and the word is lost.

## Timing
- Handshake completes at edge N. Outputs from cycle N+1: `tx_out`=0, `busy`=1, `tx_ready`=0.
- F = (2 + DATA_W + P) × CLKS_PER_BIT, where P=1 with parity and P=0 without.
- Frame occupies cycles N+1 .. N+F. IDLE is re-entered in cycle N+F+1, with `tx_ready`=1 and `tx_out`=1.
- Back-to-back: `tx_valid` held high gives the next accept at edge N+F+1 and the next start bit at cycle N+F+2. This leaves exactly one idle-high cycle between frames.
- No combinational path from inputs to outputs.

## Configuration
- `SERIAL_TX_PARITY_EN`
- Defined:
  - The PARITY state is inserted after DATA.
  - It drives even parity: XOR of the DATA_W captured bits, so the total count of ones across data and parity bits is even.
  - Frame length is (3+DATA_W)×CLKS_PER_BIT.
- Undefined:
  - The PARITY state and parity logic are absent.
  - DATA goes directly to STOP.
  - Frame length is (2+DATA_W)×CLKS_PER_BIT.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `tx_valid`=1 → `tx_out`=1, `busy`=0, no frame starts. After release, the first accept occurs at the next edge.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, send 0xA5 with no parity.
  - Line sequence, each level held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - `busy` is high for 40 cycles, and `tx_ready` returns in cycle 41.
- Parity: with `SERIAL_TX_PARITY_EN` defined, send 0xA5 (parity bit 0) then 0x07 (parity bit 1).
  - Parity level is held 4 cycles, before the stop bit.
  - Each frame is 44 cycles.
- Back-to-back: `tx_valid` held high with 0x00 then 0xFF, CLKS_PER_BIT=1.
  - Frames 0,00000000,1 and 0,11111111,1.
  - Exactly one idle-high cycle between the two frames.
  - `tx_data` is changed during the first frame, and the first frame is unaffected by the change.
- Reset mid-frame: assert `rst` for 1 cycle during bit 3 of 0x3C.
  - `tx_out`=1, `busy`=0, and `tx_ready`=1 on the following cycle.
  - A new 0x81 sent afterwards is transmitted correctly from its start bit.
